touch_adc_sequencer: RTL and testbench
======================================

// Module: touch_adc_sequencer
// PURPOSE
// - Bus master driving the SPI master's register port, upstream of it. Polls an XPT2046-style touch ADC.
// - Per sample: 3-byte frame per axis (X then Y) with slave select held low. Publishes 12-bit X/Y coordinates to the display logic.
// - Frees the CPU from per-byte SPI register traffic for the touch panel.
// PARAMETERS
// - SAMPLE_PERIOD_CYC  500000  clk cycles between frame-pair starts (100 Hz at 50 MHz)
// - WATCHDOG_CYC       4096    max cycles waiting on spi_dataavailable before abort
// - CMD_X              8'hD0   ADC command byte, X channel, 12-bit differential
// - CMD_Y              8'h90   ADC command byte, Y channel
// PORTS
// - clk                in   1   system clock, 50 MHz
// - reset_n            in   1   asynchronous, active-low reset
// - pen_irq_n          in   1   touch ADC PENIRQ, async, low = touched
// - spi_select         out  1   chip select to SPI master port
// - spi_mem_addr       out  3   register address (0 rx, 1 tx, 2 status, 3 control)
// - spi_write_n        out  1   write strobe, active low
// - spi_read_n         out  1   read strobe, active low
// - spi_data_from_cpu  out  16  write data
// - spi_data_to_cpu    in   16  read data, registered by SPI master
// - spi_dataavailable  in   1   SPI RRDY
// - spi_readyfordata   in   1   SPI TRDY
// - touch_x            out  12  last published X
// - touch_y            out  12  last published Y
// - touch_valid        out  1   1-cycle pulse: touch_x/touch_y updated
// - touch_down         out  1   synchronised pen state, updated in IDLE only
// - touch_err          out  1   sticky: watchdog abort; cleared at next successful publish
// BEHAVIOUR
// - Reset: every output 0. Exceptions: spi_write_n=1, spi_read_n=1. FSM in IDLE; period counter 0.
// - pen_irq_n passes through a 2-FF synchroniser before use.
// - Bus access:
//   - Each access holds select=1 and rd_n or wr_n=0 for exactly 2 cycles, with addr/data stable.
//   - The bus then idles 1 cycle.
//   - For reads, spi_data_to_cpu is captured at the end of the 2nd cycle.
// - FSM:
//   - IDLE -> SSO_ON when period counter expired && pen synced low. Counter restarts at SSO_ON entry.
//   - SSO_ON: write addr3 = 16'h0400 (SSO) -> TX.
//   - TX: wait spi_readyfordata, then write addr1 = byte[k] -> WAIT_RX.
//     - byte[0] = CMD_X or CMD_Y; byte[1] = byte[2] = 8'h00.
//   - WAIT_RX: wait spi_dataavailable -> RX. Watchdog expiry -> ABORT.
//   - RX: read addr0 into rx[k]. If k<2: k+1, -> TX. Else -> SSO_OFF.
//   - SSO_OFF: write addr3 = 0. If axis==X: axis=Y, k=0, -> SSO_ON. Else -> PUBLISH.
//   - PUBLISH: touch_valid=1 for 1 cycle -> IDLE.
//   - ABORT: write addr3 = 0, set touch_err, discard partial sample -> IDLE.
// - Sample = {rx[1][6:0], rx[2][7:3]}; rx[0] is ignored.
// - Watchdog: counts cycles in WAIT_RX; clears on each entry to WAIT_RX.
// - Period counter: free-running, saturates at SAMPLE_PERIOD_CYC-1 while waiting.
// - Pen release during a frame does not abort it. The completed sample is still published.
// - Reset mid-frame: returns to IDLE immediately. The SPI master shares reset_n, so SSO is cleared there too.
// - Only addresses 0,1,3 are accessed. Status is never written; RRDY is cleared by the rx read.
// CONFIGURATION
// - TOUCH_AVG_EN defined:
//   - Accumulate 4 consecutive X/Y pairs in 14-bit sums.
//   - Publish sum>>2 (truncate) once per 4 pairs; touch_valid pulses once per 4 pairs.
//   - Pen seen high in IDLE, or any ABORT, clears the sums and pair count.
// - TOUCH_AVG_EN undefined: every completed pair is published directly; no accumulators.
// STRUCTURE
// - Package touch_pkg:
//   - FSM state enum.
//   - SPI register address constants: ADDR_RX=0, ADDR_TX=1, ADDR_CTRL=3.
//   - CTRL_SSO=16'h0400.
//   - Function xpt_sample(b1,b2) returning 12 bits.
// - Sub-module touch_bus_access: 2-cycle access generator.
//   - Inputs: req, rnw, addr, wdata.
//   - Outputs: bus pins, done pulse, rdata.
// TESTING
// - Pen low, SPI model returns (00,7F,F8) X and (00,40,00) Y -> touch_x=12'hFFF, touch_y=12'h800, one touch_valid pulse.
// - Bus waveform check:
//   - Each access has select+strobe low exactly 2 cycles.
//   - Order per frame pair: ctrl 0400, tx D0, rx, tx 00, rx, tx 00, rx, ctrl 0000, then the same for 90.
// - Pen held high -> no bus activity for 3 periods; touch_down=0.
// - Model never asserts dataavailable after tx D0 -> after 4096 cycles ctrl 0000 written, touch_err=1, no touch_valid.
// - reset_n low while in WAIT_RX -> all outputs 0 asynchronously; next frame restarts with ctrl 0400.
// - TOUCH_AVG_EN: X samples 100,101,102,103 -> single touch_valid after 4th pair, touch_x=101.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types and constants for the XPT2046 touch ADC sequencer.
// Holds the sequencer FSM encoding, SPI register map and sample extraction.
package touch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSsoOn,
        StTx,
        StWaitRx,
        StRx,
        StSsoOff,
        StPublish,
        StAbort
    } touch_state_e;

    localparam logic [2:0]  ADDR_RX   = 3'd0;
    localparam logic [2:0]  ADDR_TX   = 3'd1;
    localparam logic [2:0]  ADDR_CTRL = 3'd3;
    localparam logic [15:0] CTRL_SSO  = 16'h0400;

    // The 12-bit conversion straddles the 2nd and 3rd frame bytes.
    function automatic logic [11:0] xpt_sample(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[6:0], b2[7:3]};
    endfunction

endpackage

// File: rtl/touch_bus_access.sv
// Two-cycle SPI master register access generator followed by a one-cycle idle gap.
// A request is accepted only from idle; done pulses during the gap cycle.
module touch_bus_access
    import touch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        rnw,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    input  logic [15:0] spi_data_to_cpu,
    output logic        spi_select,
    output logic [2:0]  spi_mem_addr,
    output logic        spi_write_n,
    output logic        spi_read_n,
    output logic [15:0] spi_data_from_cpu,
    output logic        done,
    output logic [15:0] rdata
);

    typedef enum logic [1:0] {BaIdle, BaAct1, BaAct2, BaGap} ba_state_e;

    ba_state_e   state_q, state_d;
    logic        rnw_q;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BaIdle;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == BaIdle && req) begin
                rnw_q   <= rnw;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == BaAct2 && rnw_q) begin
                rdata_q <= spi_data_to_cpu;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BaIdle:  if (req) state_d = BaAct1;
            BaAct1:  state_d = BaAct2;
            BaAct2:  state_d = BaGap;
            BaGap:   state_d = BaIdle;
            default: state_d = BaIdle;
        endcase
    end

    assign active            = (state_q == BaAct1) || (state_q == BaAct2);
    assign spi_select        = active;
    assign spi_write_n       = !(active && !rnw_q);
    assign spi_read_n        = !(active && rnw_q);
    assign spi_mem_addr      = addr_q;
    assign spi_data_from_cpu = wdata_q;
    assign done              = (state_q == BaGap);
    assign rdata             = rdata_q;

endmodule

// File: rtl/touch_adc_sequencer.sv
// Periodic X/Y frame-pair poller for an XPT2046-style touch ADC behind an SPI master port.
// Optional feature macro TOUCH_AVG_EN: publish the mean of every 4 consecutive pairs.
module touch_adc_sequencer
    import touch_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD_CYC = 500000,
    parameter int unsigned WATCHDOG_CYC      = 4096,
    parameter logic [7:0]  CMD_X             = 8'hD0,
    parameter logic [7:0]  CMD_Y             = 8'h90
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pen_irq_n,
    output logic        spi_select,
    output logic [2:0]  spi_mem_addr,
    output logic        spi_write_n,
    output logic        spi_read_n,
    output logic [15:0] spi_data_from_cpu,
    input  logic [15:0] spi_data_to_cpu,
    input  logic        spi_dataavailable,
    input  logic        spi_readyfordata,
    output logic [11:0] touch_x,
    output logic [11:0] touch_y,
    output logic        touch_valid,
    output logic        touch_down,
    output logic        touch_err
);

    localparam int unsigned PerW = (SAMPLE_PERIOD_CYC > 2) ? $clog2(SAMPLE_PERIOD_CYC) : 1;
    localparam int unsigned WdW  = (WATCHDOG_CYC > 2) ? $clog2(WATCHDOG_CYC) : 1;
    localparam logic [PerW-1:0] PerMax = PerW'(SAMPLE_PERIOD_CYC - 1);
    localparam logic [WdW-1:0]  WdMax  = WdW'(WATCHDOG_CYC - 1);

    touch_state_e state_q, state_d;
    logic            pen_meta_q, pen_sync_q;
    logic [PerW-1:0] per_q;
    logic [WdW-1:0]  wd_q;
    logic [1:0]      k_q;
    logic            axis_q;
    logic [7:0]      rx1_q;
    logic [11:0]     x_smp_q, y_smp_q, touch_x_q, touch_y_q;
    logic            down_q, err_q;

    logic            bus_req, bus_rnw, bus_done;
    logic [2:0]      bus_addr;
    logic [15:0]     bus_wdata, bus_rdata;
    logic [7:0]      tx_byte;
    logic            frame_start, rx_done, publish_go, abort_go;
    logic            unused_rdata;

    touch_bus_access u_bus (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (bus_req),
        .rnw               (bus_rnw),
        .addr              (bus_addr),
        .wdata             (bus_wdata),
        .spi_data_to_cpu   (spi_data_to_cpu),
        .spi_select        (spi_select),
        .spi_mem_addr      (spi_mem_addr),
        .spi_write_n       (spi_write_n),
        .spi_read_n        (spi_read_n),
        .spi_data_from_cpu (spi_data_from_cpu),
        .done              (bus_done),
        .rdata             (bus_rdata)
    );

    assign unused_rdata = ^bus_rdata[15:8];
    assign tx_byte      = (k_q == 2'd0) ? (axis_q ? CMD_Y : CMD_X) : 8'h00;

    always_comb begin
        state_d   = state_q;
        bus_req   = 1'b0;
        bus_rnw   = 1'b0;
        bus_addr  = ADDR_CTRL;
        bus_wdata = '0;
        case (state_q)
            StIdle: begin
                if (per_q == PerMax && !pen_sync_q) state_d = StSsoOn;
            end
            StSsoOn: begin
                bus_req   = 1'b1;
                bus_wdata = CTRL_SSO;
                if (bus_done) state_d = StTx;
            end
            StTx: begin
                bus_req   = spi_readyfordata;
                bus_addr  = ADDR_TX;
                bus_wdata = {8'h00, tx_byte};
                if (bus_done) state_d = StWaitRx;
            end
            StWaitRx: begin
                if (spi_dataavailable)  state_d = StRx;
                else if (wd_q == WdMax) state_d = StAbort;
            end
            StRx: begin
                bus_req  = 1'b1;
                bus_rnw  = 1'b1;
                bus_addr = ADDR_RX;
                if (bus_done) state_d = (k_q == 2'd2) ? StSsoOff : StTx;
            end
            StSsoOff: begin
                bus_req = 1'b1;
                if (bus_done) state_d = axis_q ? StPublish : StSsoOn;
            end
            StPublish: state_d = StIdle;
            StAbort: begin
                bus_req = 1'b1;
                if (bus_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign frame_start = (state_q == StIdle) && (state_d == StSsoOn);
    assign rx_done     = (state_q == StRx) && bus_done;
    assign publish_go  = (state_q == StSsoOff) && (state_d == StPublish);
    assign abort_go    = (state_q == StWaitRx) && (state_d == StAbort);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pen_meta_q <= 1'b1;
            pen_sync_q <= 1'b1;
            per_q      <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            pen_meta_q <= pen_irq_n;
            pen_sync_q <= pen_meta_q;
            if (frame_start)          per_q <= '0;
            else if (per_q != PerMax) per_q <= per_q + PerW'(1);
            wd_q <= (state_q == StWaitRx) ? wd_q + WdW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            axis_q  <= 1'b0;
            k_q     <= '0;
            rx1_q   <= '0;
            x_smp_q <= '0;
            y_smp_q <= '0;
        end else if (frame_start) begin
            axis_q <= 1'b0;
            k_q    <= '0;
        end else if (state_q == StSsoOff && bus_done) begin
            axis_q <= 1'b1;
            k_q    <= '0;
        end else if (rx_done) begin
            if (k_q == 2'd1) rx1_q <= bus_rdata[7:0];
            if (k_q == 2'd2) begin
                if (axis_q) y_smp_q <= xpt_sample(rx1_q, bus_rdata[7:0]);
                else        x_smp_q <= xpt_sample(rx1_q, bus_rdata[7:0]);
            end else begin
                k_q <= k_q + 2'd1;
            end
        end
    end

`ifdef TOUCH_AVG_EN
    logic [13:0] sum_x_q, sum_y_q, sum_x_d, sum_y_d;
    logic [1:0]  pair_q;
    logic        pub_q;

    assign sum_x_d = sum_x_q + {2'b00, x_smp_q};
    assign sum_y_d = sum_y_q + {2'b00, y_smp_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            pair_q    <= '0;
            pub_q     <= 1'b0;
            touch_x_q <= '0;
            touch_y_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (abort_go) err_q <= 1'b1;
            if (abort_go || (state_q == StIdle && pen_sync_q)) begin
                sum_x_q <= '0;
                sum_y_q <= '0;
                pair_q  <= '0;
            end else if (publish_go) begin
                if (pair_q == 2'd3) begin
                    touch_x_q <= sum_x_d[13:2];
                    touch_y_q <= sum_y_d[13:2];
                    err_q     <= 1'b0;
                    pub_q     <= 1'b1;
                    sum_x_q   <= '0;
                    sum_y_q   <= '0;
                    pair_q    <= '0;
                end else begin
                    sum_x_q <= sum_x_d;
                    sum_y_q <= sum_y_d;
                    pair_q  <= pair_q + 2'd1;
                    pub_q   <= 1'b0;
                end
            end
        end
    end

    assign touch_valid = (state_q == StPublish) && pub_q;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            touch_x_q <= '0;
            touch_y_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (abort_go) err_q <= 1'b1;
            if (publish_go) begin
                touch_x_q <= x_smp_q;
                touch_y_q <= y_smp_q;
                err_q     <= 1'b0;
            end
        end
    end

    assign touch_valid = (state_q == StPublish);
`endif

    // Pen state is only refreshed between frames so it never flickers mid-sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              down_q <= 1'b0;
        else if (state_q == StIdle) down_q <= !pen_sync_q;
    end

    assign touch_x    = touch_x_q;
    assign touch_y    = touch_y_q;
    assign touch_down = down_q;
    assign touch_err  = err_q;

endmodule

// File: tb/tb_touch_adc_sequencer.sv
// Directed bench for touch_adc_sequencer with an SPI register-port model and scoreboard.
module tb_touch_adc_sequencer;

    localparam int unsigned PERIOD = 300;

    typedef struct packed {
        logic        rnw;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pen_irq_n = 1'b1;
    logic        spi_select, spi_write_n, spi_read_n;
    logic [2:0]  spi_mem_addr;
    logic [15:0] spi_data_from_cpu;
    logic [15:0] spi_data_to_cpu = '0;
    logic        spi_dataavailable = 1'b0;
    logic        spi_readyfordata = 1'b1;
    logic [11:0] touch_x, touch_y;
    logic        touch_valid, touch_down, touch_err;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, run = 0, n_acc = 0, n_valid = 0, kb = 0, da_cnt = 0;
    int last_start_cyc = 0, last_end_cyc = 0;
    bit no_rx = 1'b0;
    acc_t cur;
    logic [23:0] cur_resp = '0;
    acc_t        exp_acc_q[$];
    logic [23:0] exp_val_q[$];
    logic [23:0] resp_q[$];
    int m_sx = 0, m_sy = 0, m_n = 0;

    always #5 clk = ~clk;

    touch_adc_sequencer #(.SAMPLE_PERIOD_CYC(PERIOD)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pen_irq_n         (pen_irq_n),
        .spi_select        (spi_select),
        .spi_mem_addr      (spi_mem_addr),
        .spi_write_n       (spi_write_n),
        .spi_read_n        (spi_read_n),
        .spi_data_from_cpu (spi_data_from_cpu),
        .spi_data_to_cpu   (spi_data_to_cpu),
        .spi_dataavailable (spi_dataavailable),
        .spi_readyfordata  (spi_readyfordata),
        .touch_x           (touch_x),
        .touch_y           (touch_y),
        .touch_valid       (touch_valid),
        .touch_down        (touch_down),
        .touch_err         (touch_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic acc_t mk(input logic rnw, input logic [2:0] addr, input logic [15:0] data);
        acc_t a;
        a.rnw = rnw;
        a.addr = addr;
        a.data = data;
        return a;
    endfunction

    task automatic model_clear();
        m_sx = 0;
        m_sy = 0;
        m_n  = 0;
    endtask

    // Queue the bus traffic and published result of one X/Y frame pair.
    task automatic expect_pair(input logic [7:0] xb1, input logic [7:0] xb2,
                               input logic [7:0] yb1, input logic [7:0] yb2);
        int xv, yv;
        xv = (int'(xb1) % 128) * 32 + int'(xb2) / 8;
        yv = (int'(yb1) % 128) * 32 + int'(yb2) / 8;
        for (int ax = 0; ax < 2; ax++) begin
            exp_acc_q.push_back(mk(1'b0, 3'd3, 16'h0400));
            exp_acc_q.push_back(mk(1'b0, 3'd1, (ax == 0) ? 16'h00D0 : 16'h0090));
            exp_acc_q.push_back(mk(1'b1, 3'd0, 16'h0000));
            for (int b = 0; b < 2; b++) begin
                exp_acc_q.push_back(mk(1'b0, 3'd1, 16'h0000));
                exp_acc_q.push_back(mk(1'b1, 3'd0, 16'h0000));
            end
            exp_acc_q.push_back(mk(1'b0, 3'd3, 16'h0000));
        end
        resp_q.push_back({8'h00, xb1, xb2});
        resp_q.push_back({8'h00, yb1, yb2});
`ifdef TOUCH_AVG_EN
        m_sx += xv;
        m_sy += yv;
        m_n++;
        if (m_n == 4) begin
            exp_val_q.push_back({12'(m_sx / 4), 12'(m_sy / 4)});
            model_clear();
        end
`else
        exp_val_q.push_back({12'(xv), 12'(yv)});
`endif
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int i = 0;
        while (n_acc < n && i < budget) begin
            @(posedge clk);
            i++;
        end
        #1;
        check(name, 32'(n_acc >= n), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_select"}, 32'(spi_select), 32'd0);
        check({tag, "_addr"}, 32'(spi_mem_addr), 32'd0);
        check({tag, "_write_n"}, 32'(spi_write_n), 32'd1);
        check({tag, "_read_n"}, 32'(spi_read_n), 32'd1);
        check({tag, "_wdata"}, 32'(spi_data_from_cpu), 32'd0);
        check({tag, "_touch_x"}, 32'(touch_x), 32'd0);
        check({tag, "_touch_y"}, 32'(touch_y), 32'd0);
        check({tag, "_valid"}, 32'(touch_valid), 32'd0);
        check({tag, "_down"}, 32'(touch_down), 32'd0);
        check({tag, "_err"}, 32'(touch_err), 32'd0);
    endtask

    // SPI port model and scoreboard; everything is sampled mid-cycle.
    always @(negedge clk) begin
        acc_t e;
        logic [23:0] v;
        cyc++;
        if (!reset_n) begin
            run = 0;
        end else begin
            if (spi_select && (!spi_read_n || !spi_write_n)) begin
                if (run == 0) begin
                    cur = mk(!spi_read_n, spi_mem_addr, spi_data_from_cpu);
                    last_start_cyc = cyc;
                end else begin
                    check("acc_stable", {13'd0, spi_mem_addr, spi_data_from_cpu},
                          {13'd0, cur.addr, cur.data});
                end
                run++;
            end else if (run > 0) begin
                check("strobe_len", 32'(run), 32'd2);
                n_acc++;
                last_end_cyc = cyc;
                if (exp_acc_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_access: got rnw=%0d addr=%0d data=%h, expected none",
                             cur.rnw, cur.addr, cur.data);
                end else begin
                    e = exp_acc_q.pop_front();
                    check("acc_rnw", 32'(cur.rnw), 32'(e.rnw));
                    check("acc_addr", 32'(cur.addr), 32'(e.addr));
                    if (!e.rnw) check("acc_wdata", 32'(cur.data), 32'(e.data));
                end
                if (!cur.rnw && cur.addr == 3'd1) begin
                    if (cur.data[7:0] == 8'hD0 || cur.data[7:0] == 8'h90) begin
                        kb = 0;
                        cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 24'h0;
                    end else if (kb < 2) begin
                        kb++;
                    end
                    spi_data_to_cpu = {8'h00, cur_resp[23 - 8 * kb -: 8]};
                    if (!no_rx) da_cnt = 3;
                end else if (cur.rnw && cur.addr == 3'd0) begin
                    spi_dataavailable = 1'b0;
                end
                run = 0;
            end
            if (da_cnt > 0) begin
                da_cnt--;
                if (da_cnt == 0) spi_dataavailable = 1'b1;
            end
            if (touch_valid) begin
                n_valid++;
                if (exp_val_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got x=%h y=%h, expected no pulse",
                             touch_x, touch_y);
                end else begin
                    v = exp_val_q.pop_front();
                    check("pub_x", 32'(touch_x), 32'(v[23:12]));
                    check("pub_y", 32'(touch_y), 32'(v[11:0]));
                end
            end
        end
    end

    initial begin
        int a0, v0, t_tx;
        #2;
        check_reset_outputs("rst");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic frame pair; pen released mid-frame must not abort it.
        expect_pair(8'h7F, 8'hF8, 8'h40, 8'h00);
        pen_irq_n = 1'b0;
        wait_acc(1, 3 * PERIOD, "t2_start");
        check("t2_down_in_frame", 32'(touch_down), 32'd1);
        pen_irq_n = 1'b1;
        model_clear();
        wait_acc(16, 1000, "t2_done");
        repeat (5) @(posedge clk);
        #1;
`ifndef TOUCH_AVG_EN
        check("t2_touch_x", 32'(touch_x), 32'h0FFF);
        check("t2_touch_y", 32'(touch_y), 32'h0800);
        check("t2_valid_cnt", 32'(n_valid), 32'd1);
`endif
        check("t2_err", 32'(touch_err), 32'd0);
        check("t2_down_after", 32'(touch_down), 32'd0);

        // Pen up: the bus must stay silent for several periods.
        a0 = n_acc;
        repeat (3 * PERIOD + 10) @(posedge clk);
        #1;
        check("t3_no_access", 32'(n_acc), 32'(a0));
        check("t3_down", 32'(touch_down), 32'd0);
        check("t3_exp_drained", 32'(exp_acc_q.size()), 32'd0);

        // Watchdog: no RRDY after the X command.
        no_rx = 1'b1;
        v0 = n_valid;
        exp_acc_q.push_back(mk(1'b0, 3'd3, 16'h0400));
        exp_acc_q.push_back(mk(1'b0, 3'd1, 16'h00D0));
        exp_acc_q.push_back(mk(1'b0, 3'd3, 16'h0000));
        a0 = n_acc;
        pen_irq_n = 1'b0;
        wait_acc(a0 + 2, 2 * PERIOD, "t4_tx_seen");
        t_tx = last_end_cyc;
        pen_irq_n = 1'b1;
        model_clear();
        wait_acc(a0 + 3, 5000, "t4_abort_seen");
        check("t4_wd_gap", 32'((last_start_cyc - t_tx) >= 4096 && (last_start_cyc - t_tx) <= 4100),
              32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t4_err", 32'(touch_err), 32'd1);
        check("t4_no_valid", 32'(n_valid), 32'(v0));

        // Reset while waiting for RRDY, then a clean frame pair.
        exp_acc_q.push_back(mk(1'b0, 3'd3, 16'h0400));
        exp_acc_q.push_back(mk(1'b0, 3'd1, 16'h00D0));
        a0 = n_acc;
        pen_irq_n = 1'b0;
        wait_acc(a0 + 2, 2 * PERIOD, "t5_tx_seen");
        repeat (20) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        spi_dataavailable = 1'b0;
        da_cnt = 0;
        no_rx = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        v0 = n_valid;
        a0 = n_acc;
        expect_pair(8'h12, 8'h34, 8'h01, 8'hFF);
        wait_acc(a0 + 1, 3 * PERIOD, "t5_restart");
        pen_irq_n = 1'b1;
        model_clear();
        wait_acc(a0 + 16, 1000, "t5_done");
        repeat (5) @(posedge clk);
        #1;
`ifndef TOUCH_AVG_EN
        check("t5_touch_x", 32'(touch_x), 32'h0246);
        check("t5_touch_y", 32'(touch_y), 32'h003F);
        check("t5_valid_cnt", 32'(n_valid), 32'(v0 + 1));
`endif
        check("t5_err", 32'(touch_err), 32'd0);

`ifdef TOUCH_AVG_EN
        // Four pairs with X = 100..103 and Y = 200 average to 101 / 200.
        v0 = n_valid;
        a0 = n_acc;
        for (int i = 0; i < 4; i++) begin
            expect_pair(8'((100 + i) / 32), 8'(((100 + i) % 32) * 8), 8'd6, 8'd64);
        end
        pen_irq_n = 1'b0;
        wait_acc(a0 + 49, 5 * PERIOD, "avg_last_pair");
        pen_irq_n = 1'b1;
        wait_acc(a0 + 64, 1000, "avg_done");
        repeat (5) @(posedge clk);
        #1;
        check("avg_touch_x", 32'(touch_x), 32'd101);
        check("avg_touch_y", 32'(touch_y), 32'd200);
        check("avg_valid_cnt", 32'(n_valid), 32'(v0 + 1));
`endif

        check("end_exp_acc_drained", 32'(exp_acc_q.size()), 32'd0);
        check("end_exp_val_drained", 32'(exp_val_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
